// File: rtl/csr_pkg.sv
// -----------------------------------------------------------------------------
// csr_pkg
// Shared definitions for the machine-mode CSR unit: CSR address map, trap
// cause constants, mstatus/mie bit positions, CSR op encodings, sequencer
// state type and the read-modify-write helper used by the CSR instructions.
// -----------------------------------------------------------------------------
package csr_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MEPC      = 12'h341,
    CSR_MCAUSE    = 12'h342,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82
  } type_csr_addr;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } type_csr_state;

  localparam logic [31:0] MCAUSE_M_TIMER = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_M_EXT   = 32'h8000_000B;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  // funct3[1:0] selects the operation; funct3[2] selects the uimm source.
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;

  // New CSR value for a CSRRW/CSRRS/CSRRC style operation.
  function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] src_val);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = src_val;
      CSR_OP_RS: res = old_val | src_val;
      CSR_OP_RC: res = old_val & ~src_val;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_if.sv
// -----------------------------------------------------------------------------
// csr_if
// Decoder/execute-stage bundle between the pipeline and the CSR unit.
//   inst_valid, inst_in, pc_in, rs1_data : instruction in the stage
//   csr_reg_rdpin, csr_reg_wrpin, is_mret: decoder strobes
//   csr_rdata                            : old value of the addressed CSR
//   epc_taken, epc_evec                  : one-cycle PC redirect
// master = pipeline side, slave = CSR unit side.
// -----------------------------------------------------------------------------
interface csr_if;
  logic        inst_valid;
  logic [31:0] inst_in;
  logic [31:0] pc_in;
  logic [31:0] rs1_data;
  logic        csr_reg_rdpin;
  logic        csr_reg_wrpin;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_evec;

  modport master (
    output inst_valid, inst_in, pc_in, rs1_data,
           csr_reg_rdpin, csr_reg_wrpin, is_mret,
    input  csr_rdata, epc_taken, epc_evec
  );

  modport slave (
    input  inst_valid, inst_in, pc_in, rs1_data,
           csr_reg_rdpin, csr_reg_wrpin, is_mret,
    output csr_rdata, epc_taken, epc_evec
  );
endinterface

// File: rtl/csr_counter64.sv
// -----------------------------------------------------------------------------
// csr_counter64
// 64-bit event counter with separately writable 32-bit halves.
//   clk, rst     : clock, synchronous active-high reset
//   inc_en       : count this cycle
//   wr_lo, wr_hi : load wdata into the low / high half
//   wdata        : write data
//   count        : current 64-bit value
// A write to either half cancels that cycle's increment entirely.
// -----------------------------------------------------------------------------
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  logic [63:0] count_r;

  // Counter register: reset, software load, or increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 64'd0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count_r[31:0]  <= wdata;
      if (wr_hi) count_r[63:32] <= wdata;
    end else if (inc_en) begin
      count_r <= count_r + 64'd1;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/csr_unit.sv
// -----------------------------------------------------------------------------
// csr_unit
// Machine-mode CSR file and trap sequencer.
//   clk, rst          : clock, synchronous active-high reset
//   timer_irq, ext_irq: level interrupt requests (registered into mip)
//   bus (csr_if.slave): instruction/strobes in, read data and redirect out
// A trap or mret decided in IDLE updates CSRs at the end of that cycle and
// produces a one-cycle epc_taken pulse in the following (REDIRECT) cycle.
// -----------------------------------------------------------------------------
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  input  logic timer_irq,
  input  logic ext_irq,
  csr_if.slave bus
);

  type_csr_state state_r, state_nx_s;

  logic        mstatus_mie_r, mstatus_mpie_r;
  logic        mie_mtie_r, mie_meie_r;
  logic        mip_mtip_r, mip_meip_r;
  logic [31:0] mtvec_r, mepc_r, mcause_r;
  logic        epc_taken_r;
  logic [31:0] epc_evec_r;

  type_csr_addr addr_s;
  logic [2:0]   funct3_s;
  logic [4:0]   src_idx_s;
  logic [31:0]  src_s, old_s, new_s;
  logic         op_writes_s, wr_en_s;
  logic         irq_pend_s, ext_sel_s, trap_s, mret_s;
  logic [31:0]  trap_cause_s, trap_target_s, mtvec_base_s;
  logic [63:0]  mcycle_s, minstret_s;
  logic         minstret_inc_s;
  logic         unused_s;

  assign addr_s    = type_csr_addr'(bus.inst_in[31:20]);
  assign src_idx_s = bus.inst_in[19:15];
  assign funct3_s  = bus.inst_in[14:12];
  assign unused_s  = ^bus.inst_in[11:0];

  assign src_s = funct3_s[2] ? {27'd0, src_idx_s} : bus.rs1_data;

  // RS/RC with a zero source field are pure reads.
  assign op_writes_s = (funct3_s[1:0] == CSR_OP_RW) ||
                       ((funct3_s[1:0] != 2'b00) && (src_idx_s != 5'd0));

  assign irq_pend_s = mstatus_mie_r &
                      ((mie_meie_r & mip_meip_r) | (mie_mtie_r & mip_mtip_r));
  assign ext_sel_s  = mie_meie_r & mip_meip_r;

  assign trap_cause_s  = ext_sel_s ? MCAUSE_M_EXT : MCAUSE_M_TIMER;
  assign mtvec_base_s  = {mtvec_r[31:2], 2'b00};
  assign trap_target_s = (mtvec_r[1:0] == 2'b01)
                         ? mtvec_base_s + {25'd0, trap_cause_s[4:0], 2'b00}
                         : mtvec_base_s;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Next state and trap/mret decision; interrupts win over a coincident mret.
  always_comb begin
    state_nx_s = state_r;
    trap_s     = 1'b0;
    mret_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.inst_valid && irq_pend_s) begin
          trap_s     = 1'b1;
          state_nx_s = REDIRECT;
        end else if (bus.inst_valid && bus.is_mret) begin
          mret_s     = 1'b1;
          state_nx_s = REDIRECT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      REDIRECT: state_nx_s = IDLE;
      default:  state_nx_s = IDLE;
    endcase
  end

  assign wr_en_s = (state_r == IDLE) && bus.inst_valid && bus.csr_reg_wrpin &&
                   op_writes_s && !trap_s;

  // Read mux: current (pre-write) value of the addressed CSR.
  always_comb begin
    old_s = 32'd0;
    case (addr_s)
      CSR_MSTATUS: begin
        old_s[MSTATUS_MIE_BIT]  = mstatus_mie_r;
        old_s[MSTATUS_MPIE_BIT] = mstatus_mpie_r;
      end
      CSR_MIE: begin
        old_s[MIE_MTIE_BIT] = mie_mtie_r;
        old_s[MIE_MEIE_BIT] = mie_meie_r;
      end
      CSR_MIP: begin
        old_s[MIP_MTIP_BIT] = mip_mtip_r;
        old_s[MIP_MEIP_BIT] = mip_meip_r;
      end
      CSR_MTVEC:     old_s = mtvec_r;
      CSR_MEPC:      old_s = mepc_r;
      CSR_MCAUSE:    old_s = mcause_r;
      CSR_MCYCLE:    old_s = mcycle_s[31:0];
      CSR_MCYCLEH:   old_s = mcycle_s[63:32];
      CSR_MINSTRET:  old_s = minstret_s[31:0];
      CSR_MINSTRETH: old_s = minstret_s[63:32];
      default:       old_s = 32'd0;
    endcase
  end

  assign new_s         = csr_apply(funct3_s[1:0], old_s, src_s);
  assign bus.csr_rdata = bus.csr_reg_rdpin ? old_s : 32'd0;

  // Architectural CSRs: trap/mret side effects take precedence over writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_r  <= 1'b0;
      mstatus_mpie_r <= 1'b0;
      mie_mtie_r     <= 1'b0;
      mie_meie_r     <= 1'b0;
      mtvec_r        <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
      mepc_r         <= 32'd0;
      mcause_r       <= 32'd0;
    end else if (trap_s) begin
      mepc_r         <= {bus.pc_in[31:2], 2'b00};
      mcause_r       <= trap_cause_s;
      mstatus_mpie_r <= mstatus_mie_r;
      mstatus_mie_r  <= 1'b0;
    end else if (mret_s) begin
      mstatus_mie_r  <= mstatus_mpie_r;
      mstatus_mpie_r <= 1'b1;
    end else if (wr_en_s) begin
      case (addr_s)
        CSR_MSTATUS: begin
          mstatus_mie_r  <= new_s[MSTATUS_MIE_BIT];
          mstatus_mpie_r <= new_s[MSTATUS_MPIE_BIT];
        end
        CSR_MIE: begin
          mie_mtie_r <= new_s[MIE_MTIE_BIT];
          mie_meie_r <= new_s[MIE_MEIE_BIT];
        end
        CSR_MTVEC:  mtvec_r  <= {new_s[31:2], 1'b0, new_s[0]};
        CSR_MEPC:   mepc_r   <= {new_s[31:2], 2'b00};
        CSR_MCAUSE: mcause_r <= new_s;
        default:    ;
      endcase
    end
  end

  // Interrupt synchroniser stage that forms mip.
  always_ff @(posedge clk) begin
    if (rst) begin
      mip_mtip_r <= 1'b0;
      mip_meip_r <= 1'b0;
    end else begin
      mip_mtip_r <= timer_irq;
      mip_meip_r <= ext_irq;
    end
  end

  // Registered redirect pulse and target.
  always_ff @(posedge clk) begin
    if (rst) begin
      epc_taken_r <= 1'b0;
      epc_evec_r  <= 32'd0;
    end else if (trap_s) begin
      epc_taken_r <= 1'b1;
      epc_evec_r  <= trap_target_s;
    end else if (mret_s) begin
      epc_taken_r <= 1'b1;
      epc_evec_r  <= mepc_r;
    end else begin
      epc_taken_r <= 1'b0;
    end
  end

  assign bus.epc_taken = epc_taken_r;
  assign bus.epc_evec  = epc_evec_r;

  // Squashed (trapped) instructions and REDIRECT-cycle bubbles do not retire.
  assign minstret_inc_s = (state_r == IDLE) && bus.inst_valid && !trap_s;

  csr_counter64 u_mcycle (
    .clk    (clk),
    .rst    (rst),
    .inc_en (1'b1),
    .wr_lo  (wr_en_s && (addr_s == CSR_MCYCLE)),
    .wr_hi  (wr_en_s && (addr_s == CSR_MCYCLEH)),
    .wdata  (new_s),
    .count  (mcycle_s)
  );

  csr_counter64 u_minstret (
    .clk    (clk),
    .rst    (rst),
    .inc_en (minstret_inc_s),
    .wr_lo  (wr_en_s && (addr_s == CSR_MINSTRET)),
    .wr_hi  (wr_en_s && (addr_s == CSR_MINSTRETH)),
    .wdata  (new_s),
    .count  (minstret_s)
  );

endmodule

// File: tb/tb_csr_unit.sv
// -----------------------------------------------------------------------------
// tb_csr_unit
// Directed bench for csr_unit. Inputs are applied just after each falling
// edge; outputs are compared 1 time unit later, well away from the rising
// edge that consumes those inputs.
// -----------------------------------------------------------------------------
module tb_csr_unit;

  logic clk = 1'b0;
  logic rst;
  logic timer_irq;
  logic ext_irq;

  // Values applied to rst/irqs at the next drive step.
  logic rst_nx   = 1'b1;
  logic timer_nx = 1'b0;
  logic ext_nx   = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  csr_if bus ();

  csr_unit #(.MTVEC_RESET(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .timer_irq (timer_irq),
    .ext_irq   (ext_irq),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus.
  task automatic drive(input logic valid, input logic [11:0] addr, input logic [2:0] f3,
                       input logic [4:0] src, input logic [31:0] rs1, input logic rd,
                       input logic wr, input logic mret, input logic [31:0] pc);
    @(negedge clk);
    rst               = rst_nx;
    timer_irq         = timer_nx;
    ext_irq           = ext_nx;
    bus.inst_valid    = valid;
    bus.inst_in       = {addr, src, f3, 5'd1, 7'h73};
    bus.rs1_data      = rs1;
    bus.csr_reg_rdpin = rd;
    bus.csr_reg_wrpin = wr;
    bus.is_mret       = mret;
    bus.pc_in         = pc;
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] addr, input logic [2:0] f3,
                        input logic [4:0] src, input logic [31:0] rs1, input logic [31:0] pc);
    drive(1'b1, addr, f3, src, rs1, 1'b1, 1'b1, 1'b0, pc);
  endtask

  task automatic csr_rd(input logic [11:0] addr);
    drive(1'b0, addr, 3'b010, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic nop(input logic valid, input logic [31:0] pc);
    drive(valid, 12'h000, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, pc);
  endtask

  initial begin
    rst = 1'b1; timer_irq = 1'b0; ext_irq = 1'b0;
    bus.inst_valid = 1'b0; bus.inst_in = 32'd0; bus.pc_in = 32'd0; bus.rs1_data = 32'd0;
    bus.csr_reg_rdpin = 1'b0; bus.csr_reg_wrpin = 1'b0; bus.is_mret = 1'b0;

    // Reset state
    nop(1'b0, 32'd0);
    nop(1'b0, 32'd0);
    check("reset_epc_taken", {31'd0, bus.epc_taken}, 32'd0);
    check("reset_epc_evec", bus.epc_evec, 32'd0);
    check("reset_rdata", bus.csr_rdata, 32'd0);
    rst_nx = 1'b0;

    csr_rd(A_MTVEC);                               check("mtvec_reset", bus.csr_rdata, 32'h0);
    csr_wr(A_MTVEC, 3'b001, 5'd1, 32'h103, 32'h0); check("rw_old_value", bus.csr_rdata, 32'h0);
    csr_rd(A_MTVEC);                               check("mtvec_bit1_forced", bus.csr_rdata, 32'h101);

    // Set / clear / RS with x0
    csr_wr(A_MSTATUS, 3'b010, 5'd1, 32'h8, 32'h0);
    csr_rd(A_MSTATUS);                             check("csrrs_mstatus", bus.csr_rdata, 32'h8);
    csr_wr(A_MSTATUS, 3'b010, 5'd0, 32'h80, 32'h0);
    csr_rd(A_MSTATUS);                             check("csrrs_x0_nowrite", bus.csr_rdata, 32'h8);
    csr_wr(A_MSTATUS, 3'b011, 5'd1, 32'h8, 32'h0); check("csrrc_old_value", bus.csr_rdata, 32'h8);
    csr_rd(A_MSTATUS);                             check("csrrc_mstatus", bus.csr_rdata, 32'h0);

    // Unimplemented address and write masks
    csr_wr(12'h123, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h0);
    csr_rd(12'h123);                               check("unimpl_reads_zero", bus.csr_rdata, 32'h0);
    csr_wr(A_MIE, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h0);
    csr_rd(A_MIE);                                 check("mie_mask", bus.csr_rdata, 32'h880);
    nop(1'b1, 32'h0);                              check("rdata_zero_no_rdpin", bus.csr_rdata, 32'h0);

    // Timer trap setup: mtvec = 0x100, MIE via CSRRSI uimm 8
    csr_wr(A_MTVEC, 3'b001, 5'd1, 32'h100, 32'h0);
    csr_wr(A_MSTATUS, 3'b110, 5'd8, 32'h0, 32'h0);
    csr_rd(A_MSTATUS);                             check("csrrsi_mie", bus.csr_rdata, 32'h8);

    // Timer trap (irq seen one cycle late; CSR write of trapped inst dropped)
    timer_nx = 1'b1;
    nop(1'b1, 32'h3C);                             check("no_trap_before_sync", {31'd0, bus.epc_taken}, 32'd0);
    csr_wr(A_MTVEC, 3'b001, 5'd1, 32'h500, 32'h40);
    check("irq_latency", {31'd0, bus.epc_taken}, 32'd0);
    nop(1'b1, 32'h44);
    check("trap_taken", {31'd0, bus.epc_taken}, 32'd1);
    check("trap_evec", bus.epc_evec, 32'h100);
    csr_rd(A_MEPC);
    check("trap_pulse_one_cycle", {31'd0, bus.epc_taken}, 32'd0);
    check("trap_mepc", bus.csr_rdata, 32'h40);
    csr_rd(A_MCAUSE);                              check("trap_mcause", bus.csr_rdata, 32'h8000_0007);
    csr_rd(A_MSTATUS);                             check("trap_mstatus", bus.csr_rdata, 32'h80);
    csr_rd(A_MTVEC);                               check("trap_wr_suppressed", bus.csr_rdata, 32'h100);

    // mret
    drive(1'b1, 12'h302, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h80);
    timer_nx = 1'b0;
    csr_rd(A_MSTATUS);
    check("mret_taken", {31'd0, bus.epc_taken}, 32'd1);
    check("mret_evec", bus.epc_evec, 32'h40);
    check("mret_mstatus", bus.csr_rdata, 32'h88);
    csr_wr(A_MTVEC, 3'b001, 5'd1, 32'h201, 32'h0);
    check("mret_pulse_one_cycle", {31'd0, bus.epc_taken}, 32'd0);

    // Vectored, external priority, coincident mret squashed
    timer_nx = 1'b1; ext_nx = 1'b1;
    nop(1'b0, 32'h0);
    drive(1'b1, 12'h302, 3'b000, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h1F0);
    nop(1'b0, 32'h0);
    check("vec_taken", {31'd0, bus.epc_taken}, 32'd1);
    check("vec_evec", bus.epc_evec, 32'h22C);
    timer_nx = 1'b0; ext_nx = 1'b0;
    csr_rd(A_MIP);                                 check("mip_both", bus.csr_rdata, 32'h880);
    csr_rd(A_MCAUSE);                              check("vec_mcause", bus.csr_rdata, 32'h8000_000B);
    csr_rd(A_MEPC);                                check("irq_over_mret_mepc", bus.csr_rdata, 32'h1F0);
    csr_rd(A_MSTATUS);                             check("vec_mstatus", bus.csr_rdata, 32'h80);

    // Counters
    csr_wr(A_MCYCLEH, 3'b001, 5'd1, 32'h5, 32'h0);
    csr_wr(A_MCYCLE, 3'b001, 5'd1, 32'hFFFF_FFFF, 32'h0);
    csr_rd(A_MCYCLE);                              check("mcycle_written", bus.csr_rdata, 32'hFFFF_FFFF);
    csr_rd(A_MCYCLEH);                             check("mcycleh_carry", bus.csr_rdata, 32'h6);
    csr_wr(A_MINSTRET, 3'b001, 5'd1, 32'h0, 32'h0);
    csr_rd(A_MINSTRET);                            check("minstret_written", bus.csr_rdata, 32'h0);
    nop(1'b1, 32'h0);
    csr_rd(A_MINSTRET);                            check("minstret_inc", bus.csr_rdata, 32'h1);

    // Reset during REDIRECT
    csr_wr(A_MSTATUS, 3'b110, 5'd8, 32'h0, 32'h0);
    timer_nx = 1'b1;
    nop(1'b0, 32'h0);
    nop(1'b1, 32'h300);
    rst_nx = 1'b1; timer_nx = 1'b0;
    nop(1'b0, 32'h0);
    check("rst_pre_taken", {31'd0, bus.epc_taken}, 32'd1);
    check("rst_pre_evec", bus.epc_evec, 32'h21C);
    rst_nx = 1'b0;
    csr_rd(A_MCYCLE);
    check("rst_epc_taken", {31'd0, bus.epc_taken}, 32'd0);
    check("rst_epc_evec", bus.epc_evec, 32'd0);
    check("rst_mcycle", bus.csr_rdata, 32'd0);
    csr_rd(A_MSTATUS);                             check("rst_mstatus", bus.csr_rdata, 32'd0);
    csr_rd(A_MEPC);                                check("rst_mepc", bus.csr_rdata, 32'd0);
    csr_rd(A_MCAUSE);                              check("rst_mcause", bus.csr_rdata, 32'd0);
    csr_rd(A_MTVEC);                               check("rst_mtvec", bus.csr_rdata, 32'd0);
    csr_rd(A_MIE);                                 check("rst_mie", bus.csr_rdata, 32'd0);
    csr_rd(A_MIP);                                 check("rst_mip", bus.csr_rdata, 32'd0);
    csr_rd(A_MINSTRET);                            check("rst_minstret", bus.csr_rdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap sequencer for the 3-stage core. It sits in the execute/writeback stage directly downstream of the instruction decoder and consumes its `csr_reg_rdpin`, `csr_reg_wrpin` and `is_mret` strobes. It supplies read data for writeback select 2'b11, handles timer and external interrupts, and issues a one-cycle PC redirect for traps and `mret`.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- inst_valid  in  1  instruction in this stage is real (not bubble or flushed).
- inst_in  in  32  instruction word. CSR address is [31:20], uimm/rs1 index is [19:15], funct3 is [14:12].
- pc_in  in  32  PC of the instruction in this stage.
- rs1_data  in  32  forwarded rs1 value.
- csr_reg_rdpin  in  1  CSR read strobe from the decoder.
- csr_reg_wrpin  in  1  CSR write strobe from the decoder.
- is_mret  in  1  SYSTEM with funct3 = 0, treated as MRET.
- timer_irq  in  1  level machine-timer interrupt.
- ext_irq  in  1  level machine-external interrupt.
- csr_rdata  out  32  old value of the addressed CSR.
- epc_taken  out  1  redirect pulse; fetch loads epc_evec and the pipeline flushes.
- epc_evec  out  32  redirect target.

## Operation
- CSR set and reset values:
  - mstatus (0x300): MIE bit 3, MPIE bit 7; other bits read 0. Reset 0.
  - mie (0x304): MTIE bit 7, MEIE bit 11. Reset 0.
  - mtvec (0x305): bit 1 forced 0. Reset MTVEC_RESET.
  - mepc (0x341): bits [1:0] forced 0. Reset 0.
  - mcause (0x342): reset 0.
  - mip (0x344): read-only. MTIP and MEIP are registered copies of the irq inputs (1-cycle sync). Reset 0.
  - mcycle/mcycleh (0xB00/0xB80) and minstret/minstreth (0xB02/0xB82): 64-bit, reset 0.
- Unimplemented addresses read 0 and ignore writes.
- CSR ops, write enable = `inst_valid & csr_reg_wrpin` and the FSM is in IDLE:
  - funct3 001 CSRRW: new = rs1_data.
  - funct3 010 CSRRS: new = old | rs1_data.
  - funct3 011 CSRRC: new = old & ~rs1_data.
  - funct3 101/110/111: the same three ops, using zero-extended uimm in place of rs1_data.
  - RS/RC with source field [19:15] = 0 perform no write.
- csr_rdata is combinational and returns the pre-write value. It is driven whenever csr_reg_rdpin is high, and is 0 otherwise.
- Counters:
  - mcycle increments every cycle.
  - minstret increments on `inst_valid` when no trap is taken that cycle.
  - A software write to either half takes priority over that cycle's increment.
- Interrupt pending:
  - irq_pend = MIE & ((MEIE & MEIP) | (MTIE & MTIP)).
  - External has priority over timer.
- FSM states: IDLE, REDIRECT.
  - IDLE → REDIRECT on trap, when `inst_valid & irq_pend`:
    - mepc <= pc_in (the instruction is squashed).
    - mcause <= 32'h8000_000B (external) or 32'h8000_0007 (timer).
    - MPIE <= MIE; MIE <= 0.
    - Target = mtvec[31:2]<<2 if mtvec[1:0] = 0; base + 4*cause_code if mtvec[1:0] = 1.
    - The instruction's CSR write is suppressed.
  - IDLE → REDIRECT on mret, when `inst_valid & is_mret & !irq_pend`:
    - MIE <= MPIE; MPIE <= 1.
    - Target = mepc.
  - Simultaneous interrupt and mret: the interrupt wins; mret is squashed and mepc = its PC.
  - REDIRECT → IDLE unconditionally. In REDIRECT, all inputs are ignored (the stage holds a flushed instruction), and the counters still run.
- Reset mid-REDIRECT returns the FSM to IDLE and clears epc_taken the next cycle.

## Timing
- Trap/mret decision is made in cycle N. CSR updates and the registered target take effect at the end of N.
- epc_taken = 1 with valid epc_evec during N+1 only. At most one pulse every 2 cycles.
- CSR writes are visible to reads in cycle N+1.
- IRQ latency: an input rising in cycle N is seen in mip in N+1, so a trap can be decided no earlier than N+1.
- Reset values of outputs: epc_taken 0, epc_evec 0, csr_rdata 0.

## Structure
- Shared package `csr_pkg` (alongside DEFS.svh) holds:
  - `type_csr_addr` enum with the addresses above.
  - mcause constants.
  - mstatus/mie bit indices.
  - `type_csr_state` {IDLE, REDIRECT}.
- Sub-module `csr_counter64`: 64-bit counter with increment enable and per-half write ports. Instantiated twice, for mcycle and minstret.

## Test plan
- Write then read: CSRRW mtvec with rs1_data = 32'h0000_0103 → next read returns 32'h0000_0101 (bit 1 forced 0).
- Set/clear: CSRRS mstatus with 32'h8, then CSRRC with 32'h8 → reads 0x8, then 0x0. CSRRS with rs1 = x0 → no change.
- Timer trap: MIE = 1, MTIE = 1, mtvec = 0x100, timer_irq = 1, pc_in = 0x40 → after 2 cycles epc_taken pulses with evec 0x100; mepc = 0x40, mcause = 0x8000_0007, MIE = 0, MPIE = 1.
- Vectored and priority: mtvec = 0x201, both irqs high → mcause = 0x8000_000B, evec = 0x22C.
- mret: after the trap above, is_mret = 1 → evec = 0x40, MIE = 1, MPIE = 1. mret coincident with a pending enabled IRQ → trap taken instead, mepc = mret PC.
- Counters and reset: write mcycle = 32'hFFFF_FFFF → mcycleh increments on the next wrap. Assert rst during REDIRECT → epc_taken 0 next cycle and all CSRs at reset values.
